// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared constants, state type and neighbour indices for the LBP window sequencer
package lbp_pkg;

    localparam int IMG_W      = 128;
    localparam int IMG_H      = 128;
    localparam int LBP_PIXELS = (IMG_W - 2) * (IMG_H - 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD9   = 3'd1,
        LOAD3   = 3'd2,
        PRESENT = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } win_state_e;

    // Byte slot of each neighbour inside the packed win_nbr bus
    localparam int G0 = 0;
    localparam int G1 = 1;
    localparam int G2 = 2;
    localparam int G3 = 3;
    localparam int G4 = 4;
    localparam int G5 = 5;
    localparam int G6 = 6;
    localparam int G7 = 7;

endpackage

// File: rtl/lbp_win_reg.sv
// rtl/lbp_win_reg.sv - 3x3 pixel window register with per-cell load and left shift
module lbp_win_reg
    import lbp_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_en,
    input  logic [1:0]    ld_row,
    input  logic [1:0]    ld_col,
    input  logic [DW-1:0] ld_data,
    input  logic          shift_en,
    output logic [DW-1:0] center,
    output logic [8*DW-1:0] nbr
);

    // w[row][col]: row 0 is r-1, col 0 is c-1
    logic [DW-1:0] w [3][3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    w[i][j] <= '0;
                end
            end
        end else if (shift_en) begin
            for (int i = 0; i < 3; i++) begin
                w[i][0] <= w[i][1];
                w[i][1] <= w[i][2];
            end
        end else if (ld_en) begin
            w[ld_row][ld_col] <= ld_data;
        end
    end

    assign center            = w[1][1];
    assign nbr[G0*DW +: DW]  = w[0][0];
    assign nbr[G1*DW +: DW]  = w[0][1];
    assign nbr[G2*DW +: DW]  = w[0][2];
    assign nbr[G3*DW +: DW]  = w[1][0];
    assign nbr[G4*DW +: DW]  = w[1][2];
    assign nbr[G5*DW +: DW]  = w[2][0];
    assign nbr[G6*DW +: DW]  = w[2][1];
    assign nbr[G7*DW +: DW]  = w[2][2];

endmodule

// File: rtl/lbp_win_ctrl.sv
// rtl/lbp_win_ctrl.sv - interior-pixel window sequencer feeding the LBP compute stage
module lbp_win_ctrl
    import lbp_pkg::*;
#(
    parameter int IMG_W = lbp_pkg::IMG_W,
    parameter int IMG_H = lbp_pkg::IMG_H,
    parameter int AW    = 14,
    parameter int DW    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            gray_ready,
    output logic            gray_req,
    output logic [AW-1:0]   gray_addr,
    input  logic [DW-1:0]   gray_data,
    output logic            win_valid,
    input  logic            win_ready,
    output logic [DW-1:0]   win_center,
    output logic [8*DW-1:0] win_nbr,
    output logic [AW-1:0]   win_addr,
    input  logic            lbp_valid,
    output logic            finish
);

    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int N_PIX  = (IMG_W - 2) * (IMG_H - 2);
    localparam int CNT_W  = $clog2(N_PIX + 1);

    win_state_e        state, state_n;
    logic [RW-1:0]     r, r_n;
    logic [CW-1:0]     c, c_n;
    logic [1:0]        lrow, lrow_n;
    logic [1:0]        lcol, lcol_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              gray_req_n;
    logic [AW-1:0]     gray_addr_n;
    logic              win_valid_n;
    logic [AW-1:0]     win_addr_n;
    logic              finish_n;
    logic              ld_en, shift_en;
    logic              rd_fire;

    // IMG_W is a power of two, so row*IMG_W+col is a plain bit concatenation
    function automatic logic [AW-1:0] mk_addr(input logic [RW-1:0] row, input logic [CW-1:0] col);
        return (AW'(row) << CW) | AW'(col);
    endfunction

    assign rd_fire = gray_req & gray_ready;

    lbp_win_reg #(.DW(DW)) u_win (
        .clk      (clk),
        .rst_n    (reset),
        .ld_en    (ld_en),
        .ld_row   (lrow),
        .ld_col   (lcol),
        .ld_data  (gray_data),
        .shift_en (shift_en),
        .center   (win_center),
        .nbr      (win_nbr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            r         <= '0;
            c         <= '0;
            lrow      <= '0;
            lcol      <= '0;
            cnt       <= '0;
            gray_req  <= 1'b0;
            gray_addr <= '0;
            win_valid <= 1'b0;
            win_addr  <= '0;
            finish    <= 1'b0;
        end else begin
            state     <= state_n;
            r         <= r_n;
            c         <= c_n;
            lrow      <= lrow_n;
            lcol      <= lcol_n;
            cnt       <= cnt_n;
            gray_req  <= gray_req_n;
            gray_addr <= gray_addr_n;
            win_valid <= win_valid_n;
            win_addr  <= win_addr_n;
            finish    <= finish_n;
        end
    end

    // Result counter runs in every state and saturates rather than wrapping
    always_comb begin
        cnt_n = cnt;
        if (lbp_valid && (cnt != {CNT_W{1'b1}})) begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_n     = state;
        r_n         = r;
        c_n         = c;
        lrow_n      = lrow;
        lcol_n      = lcol;
        gray_req_n  = gray_req;
        gray_addr_n = gray_addr;
        win_valid_n = win_valid;
        win_addr_n  = win_addr;
        finish_n    = finish;
        ld_en       = 1'b0;
        shift_en    = 1'b0;

        case (state)
            IDLE: begin
                if (gray_ready) begin
                    state_n     = LOAD9;
                    r_n         = RW'(1);
                    c_n         = CW'(1);
                    lrow_n      = 2'd0;
                    lcol_n      = 2'd0;
                    gray_req_n  = 1'b1;
                    gray_addr_n = mk_addr('0, '0);
                end
            end

            LOAD9: begin
                if (rd_fire) begin
                    ld_en = 1'b1;
                    if (lrow == 2'd2 && lcol == 2'd2) begin
                        state_n     = PRESENT;
                        gray_req_n  = 1'b0;
                        win_valid_n = 1'b1;
                        win_addr_n  = mk_addr(r, c);
                    end else begin
                        if (lrow == 2'd2) begin
                            lrow_n = 2'd0;
                            lcol_n = lcol + 2'd1;
                        end else begin
                            lrow_n = lrow + 2'd1;
                        end
                        gray_addr_n = mk_addr(r - RW'(1) + RW'(lrow_n), c - CW'(1) + CW'(lcol_n));
                    end
                end
            end

            LOAD3: begin
                if (rd_fire) begin
                    ld_en = 1'b1;
                    if (lrow == 2'd2) begin
                        state_n     = PRESENT;
                        gray_req_n  = 1'b0;
                        win_valid_n = 1'b1;
                        win_addr_n  = mk_addr(r, c);
                    end else begin
                        lrow_n      = lrow + 2'd1;
                        gray_addr_n = mk_addr(r - RW'(1) + RW'(lrow_n), c + CW'(1));
                    end
                end
            end

            PRESENT: begin
                if (win_ready) begin
                    win_valid_n = 1'b0;
                    if (c < CW'(IMG_W - 2)) begin
                        // Reuse two columns; only the new right column is fetched
                        shift_en    = 1'b1;
                        c_n         = c + CW'(1);
                        lrow_n      = 2'd0;
                        lcol_n      = 2'd2;
                        state_n     = LOAD3;
                        gray_req_n  = 1'b1;
                        gray_addr_n = mk_addr(r - RW'(1), c + CW'(2));
                    end else if (r < RW'(IMG_H - 2)) begin
                        r_n         = r + RW'(1);
                        c_n         = CW'(1);
                        lrow_n      = 2'd0;
                        lcol_n      = 2'd0;
                        state_n     = LOAD9;
                        gray_req_n  = 1'b1;
                        gray_addr_n = mk_addr(r, '0);
                    end else begin
                        state_n = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // Look at the updated count so finish rises one cycle after the last result
                if (cnt_n >= CNT_W'(N_PIX)) begin
                    state_n  = DONE;
                    finish_n = 1'b1;
                end
            end

            DONE: begin
                finish_n = 1'b1;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lbp_win_ctrl.sv
// tb/tb_lbp_win_ctrl.sv - randomized scoreboard bench for lbp_win_ctrl
module tb_lbp_win_ctrl;
    import lbp_pkg::*;

    localparam int W    = 128;
    localparam int H    = 128;
    localparam int AW   = 14;
    localparam int DW   = 8;
    localparam int NPIX = LBP_PIXELS;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            gray_ready = 1'b0;
    logic            win_ready = 1'b0;
    logic            lbp_valid = 1'b0;
    logic            gray_req, win_valid, finish;
    logic [AW-1:0]   gray_addr, win_addr;
    logic [DW-1:0]   gray_data, win_center;
    logic [8*DW-1:0] win_nbr;

    logic [DW-1:0]   mem [W*H];

    always #5 clk = ~clk;

    always_comb gray_data = mem[gray_addr];

    lbp_win_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_center (win_center),
        .win_nbr    (win_nbr),
        .win_addr   (win_addr),
        .lbp_valid  (lbp_valid),
        .finish     (finish)
    );

    typedef struct {
        int              addr;
        logic [DW-1:0]   center;
        logic [8*DW-1:0] nbr;
        int              col;
    } win_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   phase = 0;
    int   exp_rd_q[$];
    win_t exp_win_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < W*H; i++) mem[i] = DW'($urandom);
    endtask

    // Reference: row-major interior scan; a row starts with its full 3x3 block
    // read column by column, every later window reads only its new right column.
    task automatic build_model();
        win_t w;
        exp_rd_q.delete();
        exp_win_q.delete();
        for (int r = 1; r <= H-2; r++) begin
            for (int c = 1; c <= W-2; c++) begin
                if (c == 1) begin
                    for (int dc = -1; dc <= 1; dc++)
                        for (int dr = -1; dr <= 1; dr++)
                            exp_rd_q.push_back((r+dr)*W + c + dc);
                end else begin
                    for (int dr = -1; dr <= 1; dr++)
                        exp_rd_q.push_back((r+dr)*W + c + 1);
                end
                w.addr   = r*W + c;
                w.center = mem[r*W + c];
                w.col    = c;
                w.nbr    = {mem[(r+1)*W+c+1], mem[(r+1)*W+c], mem[(r+1)*W+c-1],
                            mem[r*W+c+1],                     mem[r*W+c-1],
                            mem[(r-1)*W+c+1], mem[(r-1)*W+c], mem[(r-1)*W+c-1]};
                exp_win_q.push_back(w);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gray_req"},   gray_req,   0);
        check({tag, "_gray_addr"},  gray_addr,  0);
        check({tag, "_win_valid"},  win_valid,  0);
        check({tag, "_win_center"}, win_center, 0);
        check({tag, "_win_nbr"},    win_nbr,    0);
        check({tag, "_win_addr"},   win_addr,   0);
        check({tag, "_finish"},     finish,     0);
    endtask

    // Monitor / scoreboard
    int              mon_phase = 0;
    bit              prev_ws, prev_rs, have_last, last_hs;
    int              hs_cnt, last_hs_cyc, lbp_seen, fin_chks;
    logic [AW-1:0]   rs_addr, ws_addr, last_win_addr;
    logic [DW-1:0]   ws_center;
    logic [8*DW-1:0] ws_nbr;
    win_t            mw;

    always @(negedge clk) begin
        if (phase != mon_phase) begin
            mon_phase = phase;
            prev_ws = 0; prev_rs = 0; have_last = 0; last_hs = 0;
            hs_cnt = 0; lbp_seen = 0; fin_chks = 0;
        end
        if ((phase == 1 || phase == 2) && reset) begin
            if (prev_rs) begin
                check("rd_hold_req", gray_req, 1);
                check("rd_hold_addr", gray_addr, rs_addr);
            end
            if (prev_ws) begin
                check("hold_valid", win_valid, 1);
                check("hold_addr", win_addr, ws_addr);
                check("hold_center", win_center, ws_center);
                check("hold_nbr", win_nbr, ws_nbr);
            end
            if (win_valid && !win_ready) check("stall_req", gray_req, 0);
            if (gray_req && gray_ready) begin
                if (exp_rd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_extra: got read of %0d expected no further reads", gray_addr);
                end else begin
                    check("rd_addr", gray_addr, exp_rd_q.pop_front());
                end
            end
            last_hs = win_valid && win_ready;
            if (last_hs) begin
                check("early_finish", finish, 0);
                if (exp_win_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL win_extra: got window %0d expected none", win_addr);
                end else begin
                    mw = exp_win_q.pop_front();
                    check("win_addr", win_addr, mw.addr);
                    check("win_center", win_center, mw.center);
                    check("win_nbr", win_nbr, mw.nbr);
                    if (phase == 2 && have_last)
                        check("hs_gap", 64'(cyc - last_hs_cyc), (mw.col == 1) ? 64'd10 : 64'd4);
                    have_last   = 1;
                    last_hs_cyc = cyc;
                end
                hs_cnt++;
                last_win_addr = win_addr;
            end
            if (phase == 2 && (lbp_seen == NPIX-1 || (lbp_seen >= NPIX && fin_chks < 3))) begin
                check("finish", finish, (lbp_seen >= NPIX) ? 64'd1 : 64'd0);
                if (lbp_seen >= NPIX) fin_chks++;
            end
            if (lbp_valid) lbp_seen++;
            prev_rs   = gray_req && !gray_ready;
            rs_addr   = gray_addr;
            prev_ws   = win_valid && !win_ready;
            ws_addr   = win_addr;
            ws_center = win_center;
            ws_nbr    = win_nbr;
        end else begin
            last_hs = 0;
        end
    end

    initial begin
        int stall = 0;
        bit done  = 0;

        fill_mem();
        build_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst");

        // Random back-pressure on both sides
        @(posedge clk); #1;
        phase = 1; reset = 1'b1; gray_ready = 1'b1; win_ready = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            gray_ready = ($urandom_range(0, 4) != 0);
            if (stall > 0) begin
                win_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 19) == 0) begin
                win_ready = 1'b0;
                stall = 4;
            end else begin
                win_ready = ($urandom_range(0, 2) != 0);
            end
        end
        check("progress", (hs_cnt >= 200) ? 64'd1 : 64'd0, 1);

        // Asynchronous reset in the middle of a cycle
        @(posedge clk); #3;
        phase = 3; reset = 1'b0;
        #1;
        check_zero("midrst");

        // Full image at full rate with a one-cycle lbp_valid echo
        fill_mem();
        build_model();
        repeat (2) @(posedge clk);
        #1;
        gray_ready = 1'b1; win_ready = 1'b1; lbp_valid = 1'b0;
        phase = 2; reset = 1'b1;
        for (int i = 0; i < 70000 && !done; i++) begin
            @(posedge clk); #1;
            lbp_valid = last_hs;
            if (finish) done = 1;
        end
        check("finish_set", finish, 1);
        repeat (5) begin
            @(posedge clk); #1;
            lbp_valid = 1'b0;
        end
        @(negedge clk);
        check("finish_sticky", finish, 1);
        check("last_win_addr", last_win_addr, (H-2)*W + (W-2));
        check("win_count", hs_cnt, NPIX);
        check("rd_left", exp_rd_q.size(), 0);
        check("win_left", exp_win_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lbp_win_ctrl.md
# lbp_win_ctrl

Window sequencer for the LBP engine. It scans a 128x128 grayscale image held in the gray memory and fetches each interior pixel's 3x3 neighbourhood with a sliding-column scheme (3 reads per window after row start). It presents the window to the LBP compute stage over a valid/ready handshake, counts completed LBP writes, and raises `finish`. It sits between the gray memory port and the compute/write-back datapath.

## Interface
- `IMG_W`, 128, image width in pixels (power of 2)
- `IMG_H`, 128, image height in pixels
- `AW`, 14, address width, log2(IMG_W*IMG_H)
- `DW`, 8, pixel width
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; 0 = reset asserted
- `gray_ready`  in  1  gray memory available
- `gray_req`  out  1  read request
- `gray_addr`  out  AW  read address, row*IMG_W+col
- `gray_data`  in  DW  read data, valid at the rising edge that ends a cycle with `gray_req`=1 and `gray_ready`=1 (zero-latency read)
- `win_valid`  out  1  window presented
- `win_ready`  in  1  compute stage accepts the window
- `win_center`  out  DW  pixel (r,c)
- `win_nbr`  out  8*DW  neighbours; byte k = `win_nbr[8k+7:8k]`: g0(r-1,c-1) g1(r-1,c) g2(r-1,c+1) g3(r,c-1) g4(r,c+1) g5(r+1,c-1) g6(r+1,c) g7(r+1,c+1)
- `win_addr`  out  AW  output address r*IMG_W+c
- `lbp_valid`  in  1  one LBP result written this cycle (counted)
- `finish`  out  1  all results written; sticky until reset

## Operation
- Scan covers interior pixels only: r in 1..IMG_H-2, c in 1..IMG_W-2, row-major. The block never addresses border outputs.
- A read completes only when `gray_req`=1 and `gray_ready`=1 at the rising edge. If `gray_ready`=0, the block holds `gray_addr`, drops no reads and duplicates no reads.
- FSM states:
  - IDLE: wait for `gray_ready`=1, then go to LOAD9 with r=1, c=1.
  - LOAD9: 9 reads, column-major, columns c-1, c, c+1, rows r-1, r, r+1. Then go to PRESENT.
  - PRESENT: `win_valid`=1. On `win_valid`&`win_ready`:
    - if c<IMG_W-2: shift the window left by one column, c++, go to LOAD3.
    - else if r<IMG_H-2: r++, c=1, go to LOAD9.
    - else go to DRAIN.
  - LOAD3: 3 reads of column c+1, rows r-1, r, r+1, into the right window column. Then go to PRESENT.
  - DRAIN: wait until the `lbp_valid` count reaches (IMG_W-2)*(IMG_H-2) = 15876, then go to DONE.
  - DONE: `finish`=1; stay in DONE until reset.
- `lbp_valid` is counted in every state. The counter width is 14 bits; it never wraps within one image.
- While `win_valid`=1 and `win_ready`=0, `win_center`, `win_nbr` and `win_addr` hold stable and `gray_req`=0.

## Timing
- Reset values: `gray_req`=0, `gray_addr`=0, `win_valid`=0, `win_center`=0, `win_nbr`=0, `win_addr`=0, `finish`=0. The FSM resets to IDLE and the counters to 0.
- Reset is asynchronous. Reset mid-operation clears everything immediately, and the scan restarts from r=1, c=1 once reset is released and `gray_ready`=1.
- All outputs are registered.
- Throughput with `gray_ready`=1 and `win_ready`=1:
  - row start: 9 read cycles + 1 PRESENT cycle.
  - steady state: 3 read cycles + 1 PRESENT cycle.
  - full image: 126*(10+125*4) = 64260 cycles, plus drain.
- `win_valid` rises in the cycle after the final window read is captured.
- `finish` rises the cycle after the 15876th `lbp_valid` is sampled. If that `lbp_valid` arrives before the final handshake, `finish` waits for DRAIN.

## Structure
- Shared package `lbp_pkg` holds: `IMG_W`, `IMG_H`, `LBP_PIXELS`=15876, the FSM state enum {IDLE, LOAD9, LOAD3, PRESENT, DRAIN, DONE}, and the neighbour-index constants g0..g7.
- One sub-module, `lbp_win_reg`: a 3x3 DW-bit window register with load-by-(row,col) and shift-left, exposing the centre and g0..g7.
- The FSM, row/column counters, address generation and the `lbp_valid` counter live in `lbp_win_ctrl`.

## Test plan
- Release reset with `gray_ready`=1 and `win_ready`=1 -> first 9 `gray_addr` values are 0,128,256,1,129,257,2,130,258; first `win_addr`=129; `win_center`=mem[129]; g7=mem[258].
- Second window -> reads 3,131,259; `win_addr`=130; `win_valid` asserted 4 cycles after the previous handshake.
- Row wrap: after `win_addr`=254 -> reads 128,256,384,129,257,385,130,258,386; next `win_addr`=257.
- Hold `win_ready`=0 for 5 cycles during PRESENT -> window outputs stable, `gray_req`=0 throughout; accepted on the 6th cycle.
- Drop `gray_ready` for 3 cycles after the 4th LOAD9 read -> `gray_addr` holds 129; resumes with no lost or duplicate reads; window equals golden.
- Full image with a 1-cycle-delayed `lbp_valid` echo -> last `win_addr`=16254; `finish` rises 1 cycle after the 15876th `lbp_valid`. Assert reset mid-row -> all outputs 0 immediately, and the scan restarts at address 0.
